// File: rtl/bios_block_loader.sv
// rtl/bios_block_loader.sv - BIOS image loader: download bytes -> ping-pong word banks -> BIOS RAM bursts
// Optional feature macro: BIOS_CHECKSUM_EN (8-bit byte checksum gating bios_loaded, adds bios_bad)
module bios_block_loader #(
  parameter int unsigned BLOCK_WORDS = 64,
  parameter logic [7:0]  BIOS_INDEX  = 8'h00,
  parameter logic [15:0] PAD_WORD    = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        bios_req,
  output logic        bios_wr,
  output logic [12:0] bios_addr,
  output logic [15:0] bios_din,
  output logic        bios_loaded,
  output logic        bios_overrun
`ifdef BIOS_CHECKSUM_EN
  ,
  output logic        bios_bad
`endif
);

  localparam int unsigned K  = $clog2(BLOCK_WORDS);
  localparam int unsigned LW = K + 1;
  localparam logic [K-1:0]  LAST_IDX = K'(BLOCK_WORDS - 1);
  localparam logic [LW-1:0] FULL_LEN = LW'(BLOCK_WORDS);

  typedef enum logic [1:0] {IDLE, FILL, XFER, DONE} state_t;
  state_t state_q, state_d;

  // Bank storage plus per-bank valid length; words past the length read back as PAD_WORD.
  logic [15:0]   bank_q [2][BLOCK_WORDS];
  logic [1:0]    full_q, full_d;
  logic [LW-1:0] len_q [2];
  logic [LW-1:0] len_d [2];

  logic          dl_q, dl_d, dl_done_q, dl_done_d, req_q;
  logic          wbank_q, wbank_d, rbank_q, rbank_d;
  logic [7:0]    lo_q, lo_d;
  logic [K-1:0]  lo_idx_q, lo_idx_d;
  logic          have_lo_q, have_lo_d;
  logic [LW-1:0] part_q, part_d;
  logic [K-1:0]  rptr_q, rptr_d;
  logic [12:0]   wcnt_q, wcnt_d, addr_q, addr_d;
  logic [15:0]   din_q, din_d;
  logic          loaded_q, loaded_d, overrun_q, overrun_d;
  logic          mem_we, mem_bank;
  logic [K-1:0]  mem_idx;
  logic [15:0]   mem_data;
  logic          sum_ok;

  logic          dl_act, dl_rise, dl_fall, accept, burst_end;
  logic [15:0]   rd_word;
  logic [LW-1:0] flush_len;
  logic          unused_addr;

  assign dl_act    = ioctl_download & (ioctl_index == BIOS_INDEX);
  assign dl_rise   = dl_act & ~dl_q;
  assign dl_fall   = ~dl_act & dl_q;
  assign accept    = dl_act & ioctl_wr;
  assign burst_end = (state_q == XFER) & req_q & ~bios_req;
  assign rd_word   = ({1'b0, rptr_q} < len_q[rbank_q]) ? bank_q[rbank_q][rptr_q] : PAD_WORD;
  assign flush_len = have_lo_q ? ({1'b0, lo_idx_q} + LW'(1)) : part_q;
  assign unused_addr = ^ioctl_addr[24:K+1];

  assign bios_wr      = (state_q == XFER);
  assign bios_addr    = addr_q;
  assign bios_din     = din_q;
  assign bios_loaded  = loaded_q;
  assign bios_overrun = overrun_q;

`ifdef BIOS_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       bad_q, bad_d;
  assign sum_ok   = (sum_q == 8'h00);
  assign bios_bad = bad_q;
`else
  assign sum_ok = 1'b1;
`endif

  // Datapath next state: burst read, byte packing, bank fill/free, end-of-download flush.
  always_comb begin
    full_d    = full_q;
    len_d     = len_q;
    dl_d      = dl_act;
    dl_done_d = dl_done_q;
    wbank_d   = wbank_q;
    rbank_d   = rbank_q;
    lo_d      = lo_q;
    lo_idx_d  = lo_idx_q;
    have_lo_d = have_lo_q;
    part_d    = part_q;
    rptr_d    = rptr_q;
    wcnt_d    = wcnt_q;
    addr_d    = addr_q;
    din_d     = din_q;
    overrun_d = overrun_q;
    mem_we    = 1'b0;
    mem_bank  = wbank_q;
    mem_idx   = ioctl_addr[K:1];
    mem_data  = {ioctl_dout, lo_q};
`ifdef BIOS_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    // Freeing the read bank happens before the full test so a coincident byte is not an overrun.
    if (burst_end) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
      rptr_d          = '0;
    end else if (state_q == XFER && bios_req) begin
      din_d  = rd_word;
      addr_d = wcnt_q;
      wcnt_d = wcnt_q + 13'd1;
      rptr_d = rptr_q + K'(1);
    end
    if (accept) begin
      if (full_d[0] & full_d[1]) begin
        overrun_d = 1'b1;
      end else begin
`ifdef BIOS_CHECKSUM_EN
        sum_d = sum_q + ioctl_dout;
`endif
        if (!ioctl_addr[0]) begin
          lo_d      = ioctl_dout;
          lo_idx_d  = ioctl_addr[K:1];
          have_lo_d = 1'b1;
        end else begin
          mem_we    = 1'b1;
          have_lo_d = 1'b0;
          part_d    = {1'b0, ioctl_addr[K:1]} + LW'(1);
          if (ioctl_addr[K:1] == LAST_IDX) begin
            full_d[wbank_q] = 1'b1;
            len_d[wbank_q]  = FULL_LEN;
            wbank_d         = ~wbank_q;
            part_d          = '0;
          end
        end
      end
    end
    // Partial final bank: dangling low byte gets 8'hFF high, remainder reads as pad.
    if (dl_fall) begin
      dl_done_d = 1'b1;
      if (!full_d[wbank_q] && flush_len != '0) begin
        if (have_lo_q) begin
          mem_we   = 1'b1;
          mem_idx  = lo_idx_q;
          mem_data = {8'hFF, lo_q};
        end
        full_d[wbank_q] = 1'b1;
        len_d[wbank_q]  = flush_len;
        wbank_d         = ~wbank_q;
        part_d          = '0;
        have_lo_d       = 1'b0;
      end
    end
    if (dl_rise) begin
      full_d    = '0;
      dl_done_d = 1'b0;
      wbank_d   = 1'b0;
      rbank_d   = 1'b0;
      have_lo_d = 1'b0;
      part_d    = '0;
      rptr_d    = '0;
      wcnt_d    = '0;
      overrun_d = 1'b0;
`ifdef BIOS_CHECKSUM_EN
      sum_d     = 8'h00;
`endif
    end
  end

  // Sequencer next state and the load-complete flag.
  always_comb begin
    state_d  = state_q;
    loaded_d = loaded_q;
`ifdef BIOS_CHECKSUM_EN
    bad_d    = bad_q;
`endif
    case (state_q)
      FILL: begin
        if (full_q[rbank_q])                      state_d = XFER;
        else if (dl_done_d && full_d == 2'b00)    state_d = DONE;
      end
      XFER: begin
        if (burst_end) state_d = (dl_done_d && full_d == 2'b00) ? DONE : FILL;
      end
      default: state_d = state_q;
    endcase
    if (state_d == DONE && state_q != DONE) begin
      loaded_d = sum_ok;
`ifdef BIOS_CHECKSUM_EN
      bad_d    = ~sum_ok;
`endif
    end
    if (dl_rise) begin
      state_d  = FILL;
      loaded_d = 1'b0;
`ifdef BIOS_CHECKSUM_EN
      bad_d    = 1'b0;
`endif
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      full_q    <= '0;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      dl_q      <= 1'b0;
      dl_done_q <= 1'b0;
      req_q     <= 1'b0;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      lo_q      <= '0;
      lo_idx_q  <= '0;
      have_lo_q <= 1'b0;
      part_q    <= '0;
      rptr_q    <= '0;
      wcnt_q    <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      loaded_q  <= 1'b0;
      overrun_q <= 1'b0;
`ifdef BIOS_CHECKSUM_EN
      sum_q     <= 8'h00;
      bad_q     <= 1'b0;
`endif
    end else begin
      full_q    <= full_d;
      len_q     <= len_d;
      dl_q      <= dl_d;
      dl_done_q <= dl_done_d;
      req_q     <= bios_req;
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      lo_q      <= lo_d;
      lo_idx_q  <= lo_idx_d;
      have_lo_q <= have_lo_d;
      part_q    <= part_d;
      rptr_q    <= rptr_d;
      wcnt_q    <= wcnt_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      loaded_q  <= loaded_d;
      overrun_q <= overrun_d;
`ifdef BIOS_CHECKSUM_EN
      sum_q     <= sum_d;
      bad_q     <= bad_d;
`endif
    end
  end

  // Bank write port; contents need no reset since only words below len are ever read.
  always_ff @(posedge clk_sys) begin
    if (mem_we) bank_q[mem_bank][mem_idx] <= mem_data;
  end

endmodule

// File: tb/tb_bios_block_loader.sv
// tb/tb_bios_block_loader.sv - self-checking bench for bios_block_loader (BIOS_CHECKSUM_EN aware)
module tb_bios_block_loader;
  localparam int BW = 64;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        bios_req = 1'b0;
  logic        bios_wr;
  logic [12:0] bios_addr;
  logic [15:0] bios_din;
  logic        bios_loaded;
  logic        bios_overrun;
`ifdef BIOS_CHECKSUM_EN
  logic        bios_bad;
`endif

  always #5 clk_sys = ~clk_sys;

  bios_block_loader #(.BLOCK_WORDS(BW), .BIOS_INDEX(8'h00), .PAD_WORD(16'hFFFF)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .bios_req(bios_req), .bios_wr(bios_wr),
    .bios_addr(bios_addr), .bios_din(bios_din), .bios_loaded(bios_loaded),
    .bios_overrun(bios_overrun)
`ifdef BIOS_CHECKSUM_EN
    , .bios_bad(bios_bad)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  img[$];
  logic [15:0] cap_din[$];
  logic [12:0] cap_addr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference image word: little-endian pair, missing bytes read as 8'hFF.
  function automatic logic [15:0] exp_word(input int i);
    logic [7:0] lo, hi;
    lo = (2 * i < img.size())     ? img[2 * i]     : 8'hFF;
    hi = (2 * i + 1 < img.size()) ? img[2 * i + 1] : 8'hFF;
    return {hi, lo};
  endfunction

  task automatic send_byte(input int a, input logic [7:0] d);
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  task automatic do_burst(input int n);
    for (int i = 0; i < n; i++) begin
      bios_req = 1'b1;
      @(negedge clk_sys);
      cap_din.push_back(bios_din);
      cap_addr.push_back(bios_addr);
    end
    bios_req = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic drain();
    int idle;
    idle = 0;
    for (int n = 0; n < 600 && idle < 40; n++) begin
      if (bios_wr) begin
        do_burst(BW);
        idle = 0;
      end else if (bios_loaded) begin
        break;
      end else begin
        @(negedge clk_sys);
        idle++;
      end
    end
  endtask

  task automatic run_load(input logic [7:0] idx);
    cap_din.delete();
    cap_addr.delete();
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    for (int b = 0; b < img.size(); b++) begin
      send_byte(b, img[b]);
      repeat ($urandom_range(0, 2)) @(negedge clk_sys);
      if (bios_wr) do_burst(BW);
    end
    ioctl_download = 1'b0;
    drain();
  endtask

  task automatic check_load(input string tag, input bit idx_ok);
    int   total;
    bit   exp_loaded;
    total      = idx_ok ? (((img.size() + 1) / 2 + BW - 1) / BW) * BW : 0;
    exp_loaded = idx_ok;
`ifdef BIOS_CHECKSUM_EN
    begin
      logic [7:0] s;
      s = 8'h00;
      foreach (img[i]) s = s + img[i];
      exp_loaded = idx_ok && (s == 8'h00);
    end
`endif
    chk({tag, "_nwords"}, cap_din.size(), total);
    for (int i = 0; i < total && i < cap_din.size(); i++) begin
      chk($sformatf("%s_w%0d", tag, i), cap_din[i], exp_word(i));
      chk($sformatf("%s_a%0d", tag, i), cap_addr[i], 32'(13'(i)));
    end
    chk({tag, "_loaded"}, bios_loaded, exp_loaded);
    chk({tag, "_wr_idle"}, bios_wr, 1'b0);
  endtask

  task automatic fill_random(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(8'($urandom));
  endtask

  initial begin
    logic [15:0] last_w;
    int waited;

    // Reset state
    repeat (2) @(negedge clk_sys);
    chk("rst_wr", bios_wr, 1'b0);
    chk("rst_addr", bios_addr, 13'd0);
    chk("rst_din", bios_din, 16'd0);
    chk("rst_loaded", bios_loaded, 1'b0);
    chk("rst_overrun", bios_overrun, 1'b0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Foreign index: nothing accepted, no request, not loaded
    fill_random(200);
    run_load(8'h01);
    check_load("idx01", 1'b0);

    // 256-byte counting image
    img.delete();
    for (int i = 0; i < 256; i++) img.push_back(8'(i));
    run_load(8'h00);
    check_load("t1", 1'b1);
    chk("t1_word0", cap_din.size() > 0 ? cap_din[0] : 16'hxxxx, 16'h0100);
    chk("t1_word127", cap_din.size() > 127 ? cap_din[127] : 16'hxxxx, 16'hFFFE);

    // 130-byte image: partial second bank padded
    fill_random(130);
    run_load(8'h00);
    check_load("t2", 1'b1);
    chk("t2_word65", cap_din.size() > 65 ? cap_din[65] : 16'hxxxx, 16'hFFFF);
    chk("t2_final_addr", bios_addr, 13'd127);

    // bios_req outside XFER leaves outputs unchanged
    last_w = exp_word(127);
    bios_req = 1'b1;
    repeat (3) @(negedge clk_sys);
    bios_req = 1'b0;
    @(negedge clk_sys);
    chk("req_idle_din", bios_din, last_w);
    chk("req_idle_addr", bios_addr, 13'd127);

    // Random lengths, including odd (dangling byte) lengths
    for (int r = 0; r < 4; r++) begin
      fill_random((r == 0) ? 131 : $urandom_range(1, 400));
      run_load(8'h00);
      check_load($sformatf("rnd%0d", r), 1'b1);
    end

    // Overrun: three banks of bytes with bios_req held low
    fill_random(300);
    cap_din.delete();
    cap_addr.delete();
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    for (int b = 0; b < 256; b++) send_byte(b, img[b]);
    @(negedge clk_sys);
    chk("t3_wr", bios_wr, 1'b1);
    chk("t3_no_ovr", bios_overrun, 1'b0);
    send_byte(256, img[256]);
    chk("t3_ovr", bios_overrun, 1'b1);
    for (int b = 257; b < 300; b++) send_byte(b, img[b]);
    ioctl_download = 1'b0;
    while (img.size() > 256) void'(img.pop_back());
    drain();
    check_load("t3", 1'b1);
    chk("t3_ovr_sticky", bios_overrun, 1'b1);

    // Reset mid-burst at word 10
    fill_random(128);
    cap_din.delete();
    cap_addr.delete();
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    for (int b = 0; b < 128; b++) send_byte(b, img[b]);
    waited = 0;
    while (!bios_wr && waited < 20) begin
      @(negedge clk_sys);
      waited++;
    end
    chk("t5_wr_seen", bios_wr, 1'b1);
    bios_req = 1'b1;
    repeat (10) @(negedge clk_sys);
    chk("t5_addr_pre", bios_addr, 13'd9);
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    chk("t5_wr", bios_wr, 1'b0);
    chk("t5_addr", bios_addr, 13'd0);
    chk("t5_loaded", bios_loaded, 1'b0);
    reset_n  = 1'b1;
    bios_req = 1'b0;
    repeat (2) @(negedge clk_sys);
    fill_random($urandom_range(150, 300));
    run_load(8'h00);
    check_load("t5_fresh", 1'b1);

`ifdef BIOS_CHECKSUM_EN
    // Checksum: sum 8'h01 is bad, fixing the last byte makes it good
    img.delete();
    for (int i = 0; i < 63; i++) img.push_back(8'h00);
    img.push_back(8'h01);
    run_load(8'h00);
    chk("t6_bad", bios_bad, 1'b1);
    chk("t6_loaded", bios_loaded, 1'b0);
    img[63] = 8'h00;
    run_load(8'h00);
    chk("t6_fixed_bad", bios_bad, 1'b0);
    chk("t6_fixed_loaded", bios_loaded, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
